// File: rtl/ysyx_22050518_cmp_arb.sv
// Shared 64-bit compare unit for branch (port 0) and ALU set-less-than (port 1) requesters.
// Latency: a request accepted at edge N shows its result on that port's rsp channel from edge N+1.
// Backpressure: if the one-entry result buffer is full and its owner is not ready, both request ports stall.

// Raw 64-bit comparator: signed/unsigned less-than and equality of in0 vs in1.
// Latency: purely combinational.
// Backpressure: none.
module ysyx_22050518_comp (
    input  logic [63:0] in0,
    input  logic [63:0] in1,
    output logic        slt,
    output logic        sltu,
    output logic        eq
);
    assign sltu = in0 < in1;
    assign eq   = in0 == in1;
    // With differing signs the negative operand is the smaller one; otherwise unsigned order holds.
    assign slt  = (in0[63] != in1[63]) ? in0[63] : sltu;
endmodule

// Arbiter, op decoder and result buffer around ysyx_22050518_comp.
// Latency: 1 cycle from accept to response valid; one result per cycle when the consumer keeps up.
// Backpressure: req ready is withheld from both ports while the buffered result is unconsumed.
module ysyx_22050518_cmp_arb #(
    parameter bit RR_EN    = 1'b1,
    parameter bit INIT_PRI = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_op,
    input  logic [63:0] req0_a,
    input  logic [63:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_op,
    input  logic [63:0] req1_a,
    input  logic [63:0] req1_b,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp0_res,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic        rsp1_res,
    output logic        busy
);
    logic        r_buf_v;
    logic        r_buf_id;
    logic        r_buf_res;
    logic        r_pri;

    logic        w_slot_free;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_acc;
    logic        w_sel;
    logic        w_res;
    logic [2:0]  w_op;
    logic [63:0] w_a;
    logic [63:0] w_b;
    logic        w_slt;
    logic        w_sltu;
    logic        w_eq;

    // The buffer can take a new result when empty or when its owner drains it this cycle.
    assign w_slot_free = !r_buf_v || (r_buf_id ? rsp1_ready : rsp0_ready);

    assign w_gnt0 = req0_valid && (!req1_valid || !RR_EN || !r_pri);
    assign w_gnt1 = req1_valid && !w_gnt0;

    assign req0_ready = rst_n && w_slot_free && w_gnt0;
    assign req1_ready = rst_n && w_slot_free && w_gnt1;
    assign w_acc      = req0_ready || req1_ready;
    assign w_sel      = w_gnt1;

    assign w_op = w_sel ? req1_op : req0_op;
    assign w_a  = w_sel ? req1_a  : req0_a;
    assign w_b  = w_sel ? req1_b  : req0_b;

    ysyx_22050518_comp u_comp (
        .in0  (w_a),
        .in1  (w_b),
        .slt  (w_slt),
        .sltu (w_sltu),
        .eq   (w_eq)
    );

    always_comb begin
        w_res = 1'b0;
        case (w_op)
            3'b000:  w_res = w_eq;
            3'b001:  w_res = !w_eq;
            3'b100:  w_res = w_slt;
            3'b101:  w_res = !w_slt;
            3'b110:  w_res = w_sltu;
            3'b111:  w_res = !w_sltu;
            default: w_res = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_v   <= 1'b0;
            r_buf_id  <= 1'b0;
            r_buf_res <= 1'b0;
            r_pri     <= INIT_PRI;
        end else begin
            if (w_acc) begin
                r_buf_v   <= 1'b1;
                r_buf_id  <= w_sel;
                r_buf_res <= w_res;
            end else if (r_buf_v && w_slot_free) begin
                r_buf_v <= 1'b0;
            end
            if (RR_EN && w_acc) begin
                r_pri <= !w_sel;
            end
        end
    end

    assign rsp0_valid = r_buf_v && !r_buf_id;
    assign rsp1_valid = r_buf_v && r_buf_id;
    assign rsp0_res   = rsp0_valid && r_buf_res;
    assign rsp1_res   = rsp1_valid && r_buf_res;
    assign busy       = r_buf_v;
endmodule

// File: tb/tb_ysyx_22050518_cmp_arb.sv
// Directed bench: a round-robin and a fixed-priority instance share all inputs; outputs are checked per instance.
module tb_ysyx_22050518_cmp_arb;
    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [2:0]  req0_op, req1_op;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_ready, rsp1_ready;

    logic [1:0]  rr_rq_rdy, rr_rs_vld, rr_rs_res;
    logic        rr_busy;
    logic [1:0]  fp_rq_rdy, fp_rs_vld, fp_rs_res;
    logic        fp_busy;

    int n_cmp;
    int n_err;

    logic [2:0]  t_op  [6];
    logic [63:0] t_a   [6];
    logic [63:0] t_b   [6];
    logic        t_exp [6];

    ysyx_22050518_cmp_arb #(.RR_EN(1'b1), .INIT_PRI(1'b0)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(rr_rq_rdy[0]), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(rr_rq_rdy[1]), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rr_rs_vld[0]), .rsp0_ready(rsp0_ready), .rsp0_res(rr_rs_res[0]),
        .rsp1_valid(rr_rs_vld[1]), .rsp1_ready(rsp1_ready), .rsp1_res(rr_rs_res[1]),
        .busy(rr_busy)
    );

    ysyx_22050518_cmp_arb #(.RR_EN(1'b0), .INIT_PRI(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(fp_rq_rdy[0]), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(fp_rq_rdy[1]), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(fp_rs_vld[0]), .rsp0_ready(rsp0_ready), .rsp0_res(fp_rs_res[0]),
        .rsp1_valid(fp_rs_vld[1]), .rsp1_ready(rsp1_ready), .rsp1_res(fp_rs_res[1]),
        .busy(fp_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        t_op[0] = 3'b100; t_a[0] = 64'hFFFF_FFFF_FFFF_FFFF; t_b[0] = 64'd1; t_exp[0] = 1'b1;
        t_op[1] = 3'b110; t_a[1] = 64'hFFFF_FFFF_FFFF_FFFF; t_b[1] = 64'd1; t_exp[1] = 1'b0;
        t_op[2] = 3'b000; t_a[2] = 64'd5;                   t_b[2] = 64'd5; t_exp[2] = 1'b1;
        t_op[3] = 3'b101; t_a[3] = -64'sd3;                 t_b[3] = -64'sd3; t_exp[3] = 1'b1;
        t_op[4] = 3'b111; t_a[4] = 64'd0; t_b[4] = 64'h8000_0000_0000_0000; t_exp[4] = 1'b0;
        t_op[5] = 3'b001; t_a[5] = 64'd7;                   t_b[5] = 64'd8; t_exp[5] = 1'b1;

        // Reset with a pending request: nothing may be accepted or reported.
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_op = t_op[0]; req0_a = t_a[0]; req0_b = t_b[0];
        req1_valid = 1'b0; req1_op = 3'b000; req1_a = 64'd0; req1_b = 64'd0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #11;
        check("rst_rr_rdy", rr_rq_rdy, 2'b00);
        check("rst_rr_vld", rr_rs_vld, 2'b00);
        check("rst_rr_res", rr_rs_res, 2'b00);
        check("rst_rr_busy", rr_busy, 1'b0);
        check("rst_fp_rdy", fp_rq_rdy, 2'b00);
        rst_n = 1'b1;

        // Single-port ops back to back, first one in the first cycle out of reset.
        for (int i = 0; i < 6; i++) begin
            req0_op = t_op[i]; req0_a = t_a[i]; req0_b = t_b[i];
            #1;
            check("op_rr_rdy", rr_rq_rdy, 2'b01);
            step();
            check("op_rr_vld", rr_rs_vld, 2'b01);
            check("op_rr_res", rr_rs_res[0], t_exp[i]);
            check("op_fp_res", fp_rs_res[0], t_exp[i]);
        end
        req0_valid = 1'b0;
        step();
        check("drain_rr_busy", rr_busy, 1'b0);
        check("drain_fp_busy", fp_busy, 1'b0);

        // Both valid. RR: last accepts were port 0 so port 1 is favoured first -> 1,0,1,0.
        // Port 0 EQ 5,5 -> 1; port 1 GEU 1,2 -> 0. Fixed priority always picks port 0.
        req0_valid = 1'b1; req0_op = 3'b000; req0_a = 64'd5; req0_b = 64'd5;
        req1_valid = 1'b1; req1_op = 3'b111; req1_a = 64'd1; req1_b = 64'd2;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_alt_rdy", rr_rq_rdy, (i % 2 == 0) ? 2'b10 : 2'b01);
            check("fp_pri_rdy", fp_rq_rdy, 2'b01);
            step();
            check("rr_alt_vld", rr_rs_vld, (i % 2 == 0) ? 2'b10 : 2'b01);
            check("rr_alt_res", rr_rs_res, (i % 2 == 0) ? 2'b00 : 2'b01);
            check("fp_pri_vld", fp_rs_vld, 2'b01);
            check("fp_pri_res", fp_rs_res, 2'b01);
        end
        req0_valid = 1'b0;
        #1;
        check("fp_p1_rdy", fp_rq_rdy, 2'b10);
        check("rr_p1_rdy", rr_rq_rdy, 2'b10);
        step();
        check("fp_p1_vld", fp_rs_vld, 2'b10);
        check("fp_p1_res", fp_rs_res, 2'b00);

        // Stalled consumer: buffer port 0 LT(-1,1)=1 with rsp0_ready low.
        req1_valid = 1'b0; rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 3'b100; req0_a = 64'hFFFF_FFFF_FFFF_FFFF; req0_b = 64'd1;
        #1;
        check("stall_fill_rdy", rr_rq_rdy, 2'b01);
        step();
        check("stall_fill_vld", rr_rs_vld, 2'b01);
        req0_op = 3'b000; req0_a = 64'd1; req0_b = 64'd2;
        req1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_rr_rdy", rr_rq_rdy, 2'b00);
            check("stall_fp_rdy", fp_rq_rdy, 2'b00);
            step();
            check("stall_rr_vld", rr_rs_vld, 2'b01);
            check("stall_rr_res", rr_rs_res, 2'b01);
        end
        rsp0_ready = 1'b1;
        #1;
        check("unstall_rr_rdy", rr_rq_rdy, 2'b10);
        check("unstall_fp_rdy", fp_rq_rdy, 2'b01);
        step();
        check("unstall_rr_vld", rr_rs_vld, 2'b10);
        check("unstall_rr_res", rr_rs_res, 2'b00);
        check("unstall_fp_vld", fp_rs_vld, 2'b01);
        check("unstall_fp_res", fp_rs_res, 2'b00);

        // Async reset while the buffer holds a result.
        req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        step();
        check("pre_rst_busy", rr_busy, 1'b1);
        check("pre_rst_vld", rr_rs_vld, 2'b10);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rr_vld", rr_rs_vld, 2'b00);
        check("arst_rr_busy", rr_busy, 1'b0);
        check("arst_fp_busy", fp_busy, 1'b0);
        #3;
        rst_n = 1'b1;

        // Priority back at port 0; op 011 on equal operands must still give 0.
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 3'b011; req0_a = 64'd5; req0_b = 64'd5;
        req1_valid = 1'b1; req1_op = 3'b000; req1_a = 64'd5; req1_b = 64'd5;
        #1;
        check("post_rst_rdy", rr_rq_rdy, 2'b01);
        step();
        check("op011_vld", rr_rs_vld, 2'b01);
        check("op011_res", rr_rs_res, 2'b00);
        req0_valid = 1'b0;
        #1;
        check("post_rst_p1_rdy", rr_rq_rdy, 2'b10);
        step();
        check("post_rst_p1_vld", rr_rs_vld, 2'b10);
        check("post_rst_p1_res", rr_rs_res, 2'b10);
        req1_valid = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
